// File: rtl/cpu54_regfile_gen.sv
// CPU54 general-purpose register file: 1W/2R with optional zero register and write bypass,
// per-register pending-write scoreboard, and a sequential bulk-clear engine.
module cpu54_regfile_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock_in,
  input  logic              reset_signal,
  input  logic              enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok, iss_ok, byp1, byp2;

  always_ff @(posedge clock_in or negedge reset_signal) begin
    if (!reset_signal) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state != IDLE);
    clear_done = (state == DONE);
  end

  always_ff @(posedge clock_in or negedge reset_signal) begin
    if (!reset_signal)                 clr_cnt <= '0;
    else if (state == IDLE && clear_req) clr_cnt <= '0;
    else if (state == CLEAR)           clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    wr_ok  = enable && !clear_busy && !(ZERO_REG != 0 && write_addr == '0);
    iss_ok = issue_valid && !clear_busy && !(ZERO_REG != 0 && issue_addr == '0);
  end

  always_ff @(posedge clock_in or negedge reset_signal) begin
    if (!reset_signal) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clr_cnt] <= '0;
    end else if (wr_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  // Issue is applied after the write so a same-edge issue leaves the register pending.
  always_ff @(posedge clock_in or negedge reset_signal) begin
    if (!reset_signal) begin
      pend <= '0;
    end else if (state == CLEAR) begin
      pend[clr_cnt] <= 1'b0;
    end else begin
      if (wr_ok)  pend[write_addr] <= 1'b0;
      if (iss_ok) pend[issue_addr] <= 1'b1;
    end
  end

  always_comb begin
    byp1       = (BYPASS != 0) && enable && !clear_busy && (write_addr == read_addr1);
    byp2       = (BYPASS != 0) && enable && !clear_busy && (write_addr == read_addr2);
    read_data1 = regs[read_addr1];
    busy1      = pend[read_addr1];
    read_data2 = regs[read_addr2];
    busy2      = pend[read_addr2];
    if (ZERO_REG != 0 && read_addr1 == '0) begin
      read_data1 = '0;
      busy1      = 1'b0;
    end else if (byp1) begin
      read_data1 = write_data;
      busy1      = 1'b0;
    end
    if (ZERO_REG != 0 && read_addr2 == '0) begin
      read_data2 = '0;
      busy2      = 1'b0;
    end else if (byp2) begin
      read_data2 = write_data;
      busy2      = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu54_regfile_gen.sv
// Bench for cpu54_regfile_gen: default instance (i0) and a small instance (i1: 3-bit addr,
// 16-bit data, no zero register, no bypass) checked against an array-based model every cycle.
module tb_cpu54_regfile_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       en, iv, creq;
  logic [1:0][4:0]  wa, ra1, ra2, ia;
  logic [1:0][31:0] wd;
  logic [31:0]      rd1_0, rd2_0;
  logic [15:0]      rd1_1, rd2_1;
  logic [1:0]       b1, b2, cb, cd;

  int total = 0;
  int bad   = 0;

  cpu54_regfile_gen u0 (
    .clock_in(clk), .reset_signal(rst_n), .enable(en[0]), .write_addr(wa[0]),
    .write_data(wd[0]), .read_addr1(ra1[0]), .read_addr2(ra2[0]),
    .read_data1(rd1_0), .read_data2(rd2_0), .issue_valid(iv[0]), .issue_addr(ia[0]),
    .busy1(b1[0]), .busy2(b2[0]), .clear_req(creq[0]), .clear_busy(cb[0]), .clear_done(cd[0])
  );

  cpu54_regfile_gen #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clock_in(clk), .reset_signal(rst_n), .enable(en[1]), .write_addr(wa[1][2:0]),
    .write_data(wd[1][15:0]), .read_addr1(ra1[1][2:0]), .read_addr2(ra2[1][2:0]),
    .read_data1(rd1_1), .read_data2(rd2_1), .issue_valid(iv[1]), .issue_addr(ia[1][2:0]),
    .busy1(b1[1]), .busy2(b2[1]), .clear_req(creq[1]), .clear_busy(cb[1]), .clear_done(cd[1])
  );

  // Model: register contents, pending bits, and edges elapsed since a clear was accepted.
  logic [31:0] mreg  [2][32];
  logic        mbusy [2][32];
  int          mclr  [2];

  function automatic int dep(input int c);
    return (c == 0) ? 32 : 8;
  endfunction
  function automatic logic [31:0] msk(input int c);
    return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  function automatic logic [4:0] am(input int c, input logic [4:0] a);
    return a & 5'(dep(c) - 1);
  endfunction
  function automatic bit has_zero(input int c);
    return c == 0;
  endfunction
  function automatic bit fwd(input int c, input logic [4:0] a);
    return (c == 0) && en[c] && (mclr[c] == 0) && (am(c, wa[c]) == a);
  endfunction
  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] ra);
    logic [4:0] a;
    a = am(c, ra);
    if (has_zero(c) && a == 5'd0) return '0;
    if (fwd(c, a)) return wd[c] & msk(c);
    return mreg[c][a];
  endfunction
  function automatic logic exp_busy(input int c, input logic [4:0] ra);
    logic [4:0] a;
    a = am(c, ra);
    if (has_zero(c) && a == 5'd0) return 1'b0;
    if (fwd(c, a)) return 1'b0;
    return mbusy[c][a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        mclr[c] <= 0;
        for (int i = 0; i < 32; i++) begin
          mreg[c][i]  <= '0;
          mbusy[c][i] <= 1'b0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (mclr[c] == 0) begin
          if (en[c] && !(has_zero(c) && am(c, wa[c]) == 5'd0)) begin
            mreg[c][am(c, wa[c])]  <= wd[c] & msk(c);
            mbusy[c][am(c, wa[c])] <= 1'b0;
          end
          if (iv[c] && !(has_zero(c) && am(c, ia[c]) == 5'd0))
            mbusy[c][am(c, ia[c])] <= 1'b1;
          if (creq[c]) mclr[c] <= 1;
        end else begin
          if (mclr[c] <= dep(c)) begin
            mreg[c][mclr[c] - 1]  <= '0;
            mbusy[c][mclr[c] - 1] <= 1'b0;
          end
          mclr[c] <= (mclr[c] == dep(c) + 1) ? 0 : mclr[c] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rd1_i%0d", c), (c == 0) ? rd1_0 : 32'(rd1_1), exp_rd(c, ra1[c]));
      check($sformatf("rd2_i%0d", c), (c == 0) ? rd2_0 : 32'(rd2_1), exp_rd(c, ra2[c]));
      check($sformatf("busy1_i%0d", c), 32'(b1[c]), 32'(exp_busy(c, ra1[c])));
      check($sformatf("busy2_i%0d", c), 32'(b2[c]), 32'(exp_busy(c, ra2[c])));
      check($sformatf("clear_busy_i%0d", c), 32'(cb[c]), 32'(mclr[c] != 0));
      check($sformatf("clear_done_i%0d", c), 32'(cd[c]), 32'(mclr[c] == dep(c) + 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses clear_req, attempts writes and a second request during the clear, then counts.
  task automatic run_clear(input int c, input int want);
    int n = 0;
    int pulses = 0;
    creq[c] = 1'b1;
    tick();
    creq[c] = 1'b0;
    en[c] = 1'b1;
    wa[c] = 5'd1;
    wd[c] = 32'hFFFF_FFFF;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!cb[c]) break;
      n++;
      if (cd[c]) pulses++;
      #1;
      creq[c] = (n == 3);
    end
    #1;
    en[c] = 1'b0;
    creq[c] = 1'b0;
    check($sformatf("clear_cycles_i%0d", c), 32'(n), 32'(want));
    check($sformatf("clear_pulses_i%0d", c), 32'(pulses), 32'd1);
    for (int i = 0; i < dep(c); i++) begin
      ra1[c] = 5'(i);
      ra2[c] = 5'(dep(c) - 1 - i);
      @(negedge clk);
      check($sformatf("cleared_r%0d_i%0d", i, c), (c == 0) ? rd1_0 : 32'(rd1_1), 32'h0);
      check($sformatf("idle_busy_r%0d_i%0d", i, c), 32'(b1[c]), 32'h0);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = '0; iv = '0; creq = '0; wa = '0; ra1 = '0; ra2 = '0; ia = '0; wd = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rd1", rd1_0, 32'h0);
    check("reset_clear_busy", 32'(cb[0]), 32'h0);
    #2 rst_n = 1'b1;

    tick();
    en[0] = 1; wa[0] = 5; wd[0] = 32'hDEAD_BEEF; ra1[0] = 5; ra2[0] = 5;
    tick();
    en[0] = 0;
    @(negedge clk);
    check("r5_port1", rd1_0, 32'hDEAD_BEEF);
    check("r5_port2", rd2_0, 32'hDEAD_BEEF);

    tick();
    en[0] = 1; wa[0] = 0; wd[0] = 32'h1234; ra1[0] = 0;
    @(negedge clk);
    check("r0_same_cycle", rd1_0, 32'h0);
    tick();
    en[0] = 0;
    @(negedge clk);
    check("r0_stored", rd1_0, 32'h0);

    tick();
    en[0] = 1; wa[0] = 7; wd[0] = 32'hA5A5_A5A5; ra1[0] = 7;
    @(negedge clk);
    check("bypass_r7", rd1_0, 32'hA5A5_A5A5);
    tick();
    en[0] = 0;
    @(negedge clk);
    check("stored_r7", rd1_0, 32'hA5A5_A5A5);

    tick();
    iv[0] = 1; ia[0] = 3; ra1[0] = 3;
    @(negedge clk);
    check("issue_same_cycle", 32'(b1[0]), 32'h0);
    tick();
    iv[0] = 0;
    @(negedge clk);
    check("issue_busy", 32'(b1[0]), 32'h1);
    tick();
    en[0] = 1; wa[0] = 3; wd[0] = 32'h33;
    tick();
    en[0] = 0;
    @(negedge clk);
    check("write_clears_busy", 32'(b1[0]), 32'h0);
    tick();
    en[0] = 1; wa[0] = 3; wd[0] = 32'h77; iv[0] = 1; ia[0] = 3;
    tick();
    en[0] = 0; iv[0] = 0;
    @(negedge clk);
    check("issue_write_busy", 32'(b1[0]), 32'h1);
    check("issue_write_data", rd1_0, 32'h77);

    // Small instance: r0 is writable and reads are never forwarded.
    tick();
    en[1] = 1; wa[1] = 0; wd[1] = 32'hBEEF; ra1[1] = 0;
    @(negedge clk);
    check("i1_r0_no_bypass", 32'(rd1_1), 32'h0);
    tick();
    en[1] = 1; wa[1] = 7; wd[1] = 32'h1111;
    @(negedge clk);
    check("i1_r0_stored", 32'(rd1_1), 32'hBEEF);
    tick();
    wd[1] = 32'hA5A5; ra1[1] = 7;
    @(negedge clk);
    check("i1_r7_old", 32'(rd1_1), 32'h1111);
    tick();
    en[1] = 0;
    @(negedge clk);
    check("i1_r7_new", 32'(rd1_1), 32'hA5A5);
    tick();
    run_clear(1, 9);

    tick();
    for (int i = 0; i < 32; i++) begin
      en[0] = 1; wa[0] = 5'(i); wd[0] = 32'(i + 1);
      tick();
    end
    en[0] = 0;
    for (int i = 1; i <= 4; i++) begin
      iv[0] = 1; ia[0] = 5'(i);
      tick();
    end
    iv[0] = 0; ra1[0] = 31; ra2[0] = 2;
    @(negedge clk);
    check("fill_r31", rd1_0, 32'd32);
    check("fill_busy_r2", 32'(b2[0]), 32'h1);
    tick();
    run_clear(0, 33);

    tick();
    en[0] = 1; wa[0] = 20; wd[0] = 32'h2020;
    tick();
    en[0] = 0; ra1[0] = 20; creq[0] = 1;
    tick();
    creq[0] = 0;
    repeat (10) tick();
    @(negedge clk);
    check("midclear_r20", rd1_0, 32'h2020);
    check("midclear_busy", 32'(cb[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_clear_busy", 32'(cb[0]), 32'h0);
    check("abort_r20", rd1_0, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    run_clear(0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
